// File: rtl/mic_array_scheduler.sv
// Frame sequencer for an I2S microphone array: drives WS, snapshots every decoder's
// L/R words once per frame and drains them as an ordered valid/ready word stream.
module mic_array_scheduler #(
    parameter int unsigned NUM_PAIRS = 4,
    parameter int unsigned DATAWIDTH = 24,
    parameter int unsigned CHW       = 6
) (
    input  logic                           clk_mic,
    input  logic                           rst_mic,
    input  logic                           enable,
    input  logic                           ovf_clr,
    input  logic [NUM_PAIRS*DATAWIDTH-1:0] l_data_bus,
    input  logic [NUM_PAIRS*DATAWIDTH-1:0] r_data_bus,
    output logic                           ws,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATAWIDTH-1:0]           m_data,
    output logic [CHW-1:0]                 m_chan,
    output logic                           m_last,
    output logic [15:0]                    frame_cnt,
    output logic                           overflow
);

    localparam int unsigned NCH   = 2 * NUM_PAIRS;
    localparam int unsigned SNAPW = NCH * DATAWIDTH;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    logic [5:0]           bit_cnt_q,   bit_cnt_d;
    logic                 primed_q,    primed_d;
    logic                 state_q,     state_d;
    logic [SNAPW-1:0]     snap_q,      snap_d;
    logic                 m_valid_q,   m_valid_d;
    logic [DATAWIDTH-1:0] m_data_q,    m_data_d;
    logic [CHW-1:0]       m_chan_q,    m_chan_d;
    logic                 m_last_q,    m_last_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 overflow_q,  overflow_d;

    logic                 fb_c;
    logic                 hs_c;
    logic                 drain_free_c;
    logic                 capture_c;
    logic [CHW-1:0]       chan_nxt_c;
    logic [DATAWIDTH-1:0] word_nxt_c;
    logic [SNAPW-1:0]     snap_new_c;

    // Interleave the decoder buses into channel order: 2k = left, 2k+1 = right.
    always_comb begin
        snap_new_c = '0;
        for (int k = 0; k < int'(NUM_PAIRS); k++) begin
            snap_new_c[(2*k)*DATAWIDTH   +: DATAWIDTH] = l_data_bus[k*DATAWIDTH +: DATAWIDTH];
            snap_new_c[(2*k+1)*DATAWIDTH +: DATAWIDTH] = r_data_bus[k*DATAWIDTH +: DATAWIDTH];
        end
    end

    // Snapshot word for the channel following the one being presented.
    always_comb begin
        chan_nxt_c = m_chan_q + CHW'(1);
        word_nxt_c = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (chan_nxt_c == CHW'(c)) begin
                word_nxt_c = snap_q[c*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        primed_d    = primed_q;
        state_d     = state_q;
        snap_d      = snap_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_chan_d    = m_chan_q;
        m_last_d    = m_last_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;

        fb_c         = enable && (bit_cnt_q == 6'd63);
        hs_c         = m_valid_q && m_ready;
        drain_free_c = (state_q == ST_IDLE) || (hs_c && m_last_q);
        capture_c    = fb_c && primed_q && drain_free_c;

        bit_cnt_d  = enable ? bit_cnt_q + 6'd1 : 6'd32;
        primed_d   = enable && (primed_q || fb_c);
        overflow_d = (fb_c && primed_q && !drain_free_c) || (overflow_q && !ovf_clr);

        case (state_q)
            ST_SEND: begin
                if (hs_c) begin
                    if (m_last_q) begin
                        state_d   = ST_IDLE;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        m_chan_d = chan_nxt_c;
                        m_data_d = word_nxt_c;
                        m_last_d = (chan_nxt_c == CHW'(NCH - 1));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A capture overrides the drain step, including the back-to-back restart.
        if (capture_c) begin
            snap_d      = snap_new_c;
            state_d     = ST_SEND;
            m_valid_d   = 1'b1;
            m_chan_d    = '0;
            m_data_d    = snap_new_c[DATAWIDTH-1:0];
            m_last_d    = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_mic) begin
        if (rst_mic) begin
            bit_cnt_q   <= 6'd32;
            primed_q    <= 1'b0;
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_chan_q    <= '0;
            m_last_q    <= 1'b0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            primed_q    <= primed_d;
            state_q     <= state_d;
            snap_q      <= snap_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_chan_q    <= m_chan_d;
            m_last_q    <= m_last_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign ws        = bit_cnt_q[5];
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_chan    = m_chan_q;
    assign m_last    = m_last_q;
    assign frame_cnt = frame_cnt_q;
    assign overflow  = overflow_q;

endmodule
